// File: rtl/cache_nway_writeback_pkg.sv
// Shared types for the N-way write-back cache: controller states and counter width.
package cache_nway_writeback_pkg;

    localparam int CNT_WIDTH = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_WB     = 3'd2,
        ST_REFILL = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

endpackage

// File: rtl/cache_nway_writeback_if.sv
// CPU request/response and block-memory transfer signals of the cache.
// slave is the cache side, master is the CPU plus backing memory side.
interface cache_nway_writeback_if #(
    parameter int DATA_WIDTH         = 32,
    parameter int ADDR_WIDTH         = 10,
    parameter int BLOCK_OFFSET_WIDTH = 3
);
    localparam int BLOCK_BITS = DATA_WIDTH << BLOCK_OFFSET_WIDTH;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_hit;
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [BLOCK_BITS-1:0] mem_wblock;
    logic [BLOCK_BITS-1:0] mem_rblock;
    logic                  mem_valid;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, mem_rblock, mem_valid,
        output req_ready, resp_valid, resp_rdata, resp_hit,
               mem_req, mem_we, mem_addr, mem_wblock
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, mem_rblock, mem_valid,
        input  req_ready, resp_valid, resp_rdata, resp_hit,
               mem_req, mem_we, mem_addr, mem_wblock
    );
endinterface

// File: rtl/cache_lru_set.sv
// True-LRU age store for every set: age 0 = most recent, ways-1 = victim.
module cache_lru_set #(
    parameter int INDEX_WIDTH = 4,
    parameter int WAY_WIDTH   = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INDEX_WIDTH-1:0] rd_idx,
    output logic [WAY_WIDTH-1:0]   victim,
    input  logic                   upd_en,
    input  logic [INDEX_WIDTH-1:0] upd_idx,
    input  logic [WAY_WIDTH-1:0]   upd_way
);
    localparam int SETS = 1 << INDEX_WIDTH;
    localparam int WAYS = 1 << WAY_WIDTH;

    logic [WAY_WIDTH-1:0] age_q [SETS][WAYS];

    // Victim is the way carrying the oldest age in the addressed set.
    always_comb begin
        victim = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (age_q[rd_idx][w] == WAY_WIDTH'(WAYS - 1)) victim = WAY_WIDTH'(w);
        end
    end

    // Accessed way becomes youngest; ways younger than it age by one, so ages stay a permutation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++)
                    age_q[s][w] <= WAY_WIDTH'(w);
        end else if (upd_en) begin
            for (int w = 0; w < WAYS; w++) begin
                if (WAY_WIDTH'(w) == upd_way)
                    age_q[upd_idx][w] <= '0;
                else if (age_q[upd_idx][w] < age_q[upd_idx][upd_way])
                    age_q[upd_idx][w] <= age_q[upd_idx][w] + WAY_WIDTH'(1);
            end
        end
    end
endmodule

// File: rtl/cache_nway_writeback.sv
// N-way set-associative write-back, write-allocate data cache with true-LRU
// replacement, dirty-only write-back and saturating hit/miss counters.
module cache_nway_writeback
    import cache_nway_writeback_pkg::*;
#(
    parameter int DATA_WIDTH         = 32,
    parameter int ADDR_WIDTH         = 10,
    parameter int INDEX_WIDTH        = 4,
    parameter int BLOCK_OFFSET_WIDTH = 3,
    parameter int WAY_WIDTH          = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    cache_nway_writeback_if.slave bus,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count
);
    localparam int TAG_WIDTH  = ADDR_WIDTH - INDEX_WIDTH - BLOCK_OFFSET_WIDTH;
    localparam int BLOCK_BITS = DATA_WIDTH << BLOCK_OFFSET_WIDTH;
    localparam int SETS       = 1 << INDEX_WIDTH;
    localparam int WAYS       = 1 << WAY_WIDTH;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + CNT_WIDTH'(1);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] get_word(input logic [BLOCK_BITS-1:0] blk,
                                                       input logic [BLOCK_OFFSET_WIDTH-1:0] o);
        return blk[DATA_WIDTH*int'(o) +: DATA_WIDTH];
    endfunction

    function automatic logic [BLOCK_BITS-1:0] put_word(input logic [BLOCK_BITS-1:0] blk,
                                                       input logic [BLOCK_OFFSET_WIDTH-1:0] o,
                                                       input logic [DATA_WIDTH-1:0] w);
        logic [BLOCK_BITS-1:0] r;
        r = blk;
        r[DATA_WIDTH*int'(o) +: DATA_WIDTH] = w;
        return r;
    endfunction

    state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] addr_p0;
    logic                  we_p0;
    logic [DATA_WIDTH-1:0] wdata_p0;
    logic [WAY_WIDTH-1:0]  victim_p0;

    logic [WAYS-1:0]       valid_q [SETS];
    logic [WAYS-1:0]       dirty_q [SETS];
    logic [TAG_WIDTH-1:0]  tag_q   [SETS][WAYS];
    logic [BLOCK_BITS-1:0] data_q  [SETS][WAYS];

    logic [INDEX_WIDTH-1:0]        idx;
    logic [TAG_WIDTH-1:0]          tag;
    logic [BLOCK_OFFSET_WIDTH-1:0] off;
    logic                          hit, lookup_hit, fill;
    logic [WAY_WIDTH-1:0]          hit_way, miss_way, lru_victim, wr_way;
    logic [BLOCK_BITS-1:0]         wr_block;

    assign idx        = addr_p0[BLOCK_OFFSET_WIDTH +: INDEX_WIDTH];
    assign tag        = addr_p0[ADDR_WIDTH-1 -: TAG_WIDTH];
    assign off        = addr_p0[BLOCK_OFFSET_WIDTH-1:0];
    assign lookup_hit = (state_q == ST_LOOKUP) && hit;
    assign fill       = (state_q == ST_REFILL) && bus.mem_valid;
    assign wr_way     = fill ? victim_p0 : hit_way;

    cache_lru_set #(
        .INDEX_WIDTH (INDEX_WIDTH),
        .WAY_WIDTH   (WAY_WIDTH)
    ) u_lru (
        .clk     (clk),
        .rst     (rst),
        .rd_idx  (idx),
        .victim  (lru_victim),
        .upd_en  (lookup_hit || fill),
        .upd_idx (idx),
        .upd_way (wr_way)
    );

    // Tag match across ways; miss victim prefers the lowest invalid way, else LRU.
    always_comb begin
        hit      = 1'b0;
        hit_way  = '0;
        miss_way = lru_victim;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
                hit     = 1'b1;
                hit_way = WAY_WIDTH'(w);
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[idx][w]) miss_way = WAY_WIDTH'(w);
        end
    end

    // Line image to store: refill block or current line, with the write word merged in.
    always_comb begin
        wr_block = fill ? bus.mem_rblock : data_q[idx][hit_way];
        if (we_p0) wr_block = put_word(wr_block, off, wdata_p0);
    end

    // Controller next state and all bus outputs.
    always_comb begin
        state_d        = state_q;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_hit   = 1'b0;
        bus.resp_rdata = '0;
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wblock = '0;
        unique case (state_q)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) state_d = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                if (hit) begin
                    bus.resp_valid = 1'b1;
                    bus.resp_hit   = 1'b1;
                    if (!we_p0) bus.resp_rdata = get_word(data_q[idx][hit_way], off);
                    state_d = ST_IDLE;
                end else if (valid_q[idx][miss_way] && dirty_q[idx][miss_way]) begin
                    state_d = ST_WB;
                end else begin
                    state_d = ST_REFILL;
                end
            end
            ST_WB: begin
                bus.mem_req    = 1'b1;
                bus.mem_we     = 1'b1;
                bus.mem_addr   = {tag_q[idx][victim_p0], idx, {BLOCK_OFFSET_WIDTH{1'b0}}};
                bus.mem_wblock = data_q[idx][victim_p0];
                if (bus.mem_valid) state_d = ST_REFILL;
            end
            ST_REFILL: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = {tag, idx, {BLOCK_OFFSET_WIDTH{1'b0}}};
                if (bus.mem_valid) state_d = ST_RESP;
            end
            ST_RESP: begin
                bus.resp_valid = 1'b1;
                if (!we_p0) bus.resp_rdata = get_word(data_q[idx][victim_p0], off);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register; reset abandons any transfer in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Request capture on accept and victim latch on a lookup miss.
    always_ff @(posedge clk) begin
        if ((state_q == ST_IDLE) && bus.req_valid) begin
            addr_p0  <= bus.req_addr;
            we_p0    <= bus.req_we;
            wdata_p0 <= bus.req_wdata;
        end
        if ((state_q == ST_LOOKUP) && !hit) victim_p0 <= miss_way;
    end

    // Valid and dirty bits: write hits dirty the line, fills reload them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
            end
        end else begin
            if (lookup_hit && we_p0) dirty_q[idx][hit_way] <= 1'b1;
            if (fill) begin
                valid_q[idx][victim_p0] <= 1'b1;
                dirty_q[idx][victim_p0] <= we_p0;
            end
        end
    end

    // Tag and data storage; contents are meaningless until the valid bit is set.
    always_ff @(posedge clk) begin
        if ((lookup_hit && we_p0) || fill) data_q[idx][wr_way] <= wr_block;
        if (fill) tag_q[idx][victim_p0] <= tag;
    end

    // Saturating hit/miss statistics, decided in the lookup cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state_q == ST_LOOKUP) begin
            if (hit) hit_count  <= sat_inc(hit_count);
            else     miss_count <= sat_inc(miss_count);
        end
    end
endmodule

// File: tb/tb_cache_nway_writeback.sv
// Self-checking bench for cache_nway_writeback: directed scenarios plus random
// traffic compared against a recency-list cache model and a flat golden memory.
module tb_cache_nway_writeback;
    localparam int SETS = 16;
    localparam int WAYS = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] hit_count, miss_count;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0]  phys_mem [1024];
    logic [31:0]  arch_mem [1024];
    bit           q_we   [$];
    logic [9:0]   q_addr [$];
    logic [255:0] q_blk  [$];

    bit m_valid [SETS][WAYS];
    bit m_dirty [SETS][WAYS];
    int m_tag   [SETS][WAYS];
    int m_order [SETS][WAYS];
    int m_hits, m_misses;

    cache_nway_writeback_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .BLOCK_OFFSET_WIDTH(3)) bus ();

    cache_nway_writeback dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 0;
                m_dirty[s][w] = 0;
                m_tag[s][w]   = 0;
                m_order[s][w] = w;
            end
        m_hits = 0;
        m_misses = 0;
    endtask

    // Move a way to the most-recent end of its set's recency list.
    task automatic model_touch(input int s, input int w);
        int p;
        p = 0;
        for (int i = 0; i < WAYS; i++) if (m_order[s][i] == w) p = i;
        for (int i = p; i > 0; i--) m_order[s][i] = m_order[s][i-1];
        m_order[s][0] = w;
    endtask

    task automatic model_access(input bit we, input logic [9:0] addr,
                                output bit hit, output bit wb, output int wb_addr);
        int t, s, way;
        t = int'(addr) >> 7;
        s = (int'(addr) >> 3) & 15;
        hit = 0; wb = 0; wb_addr = 0; way = 0;
        for (int w = 0; w < WAYS; w++)
            if (m_valid[s][w] && m_tag[s][w] == t) begin hit = 1; way = w; end
        if (hit) begin
            m_hits++;
            if (we) m_dirty[s][way] = 1;
        end else begin
            m_misses++;
            way = m_order[s][WAYS-1];
            for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[s][w]) way = w;
            wb = m_valid[s][way] && m_dirty[s][way];
            wb_addr = (m_tag[s][way] << 7) | (s << 3);
            m_valid[s][way] = 1;
            m_tag[s][way]   = t;
            m_dirty[s][way] = we;
        end
        model_touch(s, way);
    endtask

    // Backing memory: answers each held mem_req after three sampled cycles.
    initial begin
        int cnt;
        cnt = 0;
        bus.mem_valid  = 1'b0;
        bus.mem_rblock = '0;
        forever begin
            @(negedge clk);
            bus.mem_valid = 1'b0;
            if (rst || !bus.mem_req) begin
                cnt = 0;
            end else begin
                cnt++;
                if (cnt == 3) begin
                    cnt = 0;
                    q_we.push_back(bus.mem_we);
                    q_addr.push_back(bus.mem_addr);
                    q_blk.push_back(bus.mem_wblock);
                    for (int i = 0; i < 8; i++) begin
                        if (bus.mem_we) phys_mem[int'(bus.mem_addr) + i] = bus.mem_wblock[i*32 +: 32];
                        else bus.mem_rblock[i*32 +: 32] = phys_mem[int'(bus.mem_addr) + i];
                    end
                    bus.mem_valid = 1'b1;
                end
            end
        end
    end

    task automatic do_req(input bit we, input logic [9:0] addr, input logic [31:0] wd);
        bit           e_hit, e_wb;
        int           e_wb_addr, n, ri, nx;
        logic [255:0] e_blk;
        logic [31:0]  e_rd;
        n = 0;
        while (!bus.req_ready && n < 100) begin @(negedge clk); n++; end
        check_eq("req_ready", bus.req_ready, 1);
        if (!bus.req_ready) return;
        model_access(we, addr, e_hit, e_wb, e_wb_addr);
        e_blk = '0;
        if (e_wb) for (int i = 0; i < 8; i++) e_blk[i*32 +: 32] = arch_mem[e_wb_addr + i];
        e_rd = arch_mem[addr];
        q_we.delete(); q_addr.delete(); q_blk.delete();
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr; bus.req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        n = 1;
        while (!bus.resp_valid && n < 200) begin @(negedge clk); n++; end
        check_eq("resp_valid", bus.resp_valid, 1);
        check_eq("resp_hit", bus.resp_hit, e_hit);
        if (e_hit) check_eq("hit_latency", n, 1);
        if (!we) check_eq("rdata", bus.resp_rdata, e_rd);
        else arch_mem[addr] = wd;
        @(negedge clk);
        check_eq("resp_pulse", bus.resp_valid, 0);
        check_eq("hit_count", hit_count, m_hits);
        check_eq("miss_count", miss_count, m_misses);
        nx = e_hit ? 0 : (e_wb ? 2 : 1);
        check_eq("xfer_count", q_we.size(), nx);
        if (nx != 0 && q_we.size() == nx) begin
            ri = 0;
            if (e_wb) begin
                check_eq("wb_we", q_we[0], 1);
                check_eq("wb_addr", q_addr[0], e_wb_addr);
                check_eq("wb_block", q_blk[0], e_blk);
                ri = 1;
            end
            check_eq("refill_we", q_we[ri], 0);
            check_eq("refill_addr", q_addr[ri], addr & 10'h3F8);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [9:0]  ra;
        bit          rwe;
        logic [31:0] rwd;
        int          n;
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        for (int i = 0; i < 1024; i++) begin
            phys_mem[i] = $urandom;
            arch_mem[i] = phys_mem[i];
        end
        model_reset();
        repeat (2) @(negedge clk);
        check_eq("reset_req_ready", bus.req_ready, 1);
        check_eq("reset_resp_valid", bus.resp_valid, 0);
        check_eq("reset_mem_req", bus.mem_req, 0);
        check_eq("reset_hit_count", hit_count, 0);
        check_eq("reset_miss_count", miss_count, 0);
        rst = 1'b0;
        @(negedge clk);

        do_req(0, 10'h000, 0);
        check_eq("cold_miss_count", miss_count, 1);
        do_req(0, 10'h001, 0);
        check_eq("rehit_count", hit_count, 1);
        do_req(1, 10'h002, 32'hDEADBEEF);
        do_req(0, 10'h002, 0);
        do_req(0, 10'h080, 0);
        do_req(0, 10'h000, 0);
        do_req(0, 10'h100, 0);
        do_req(0, 10'h180, 0);
        check_eq("wb_landed", phys_mem[10'h002], 32'hDEADBEEF);
        do_req(0, 10'h200, 0);

        // Reset while a refill is outstanding.
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 10'h3C8; bus.req_wdata = '0;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        n = 0;
        while (!(bus.mem_req && !bus.mem_we) && n < 50) begin @(negedge clk); n++; end
        check_eq("refill_seen", bus.mem_req && !bus.mem_we, 1);
        #1 rst = 1'b1;
        #1;
        check_eq("rst_mem_req", bus.mem_req, 0);
        check_eq("rst_req_ready", bus.req_ready, 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 1024; i++) arch_mem[i] = phys_mem[i];
        model_reset();
        check_eq("rst_hit_count", hit_count, 0);
        check_eq("rst_miss_count", miss_count, 0);
        do_req(0, 10'h3C8, 0);

        for (int k = 0; k < 250; k++) begin
            ra  = {3'($urandom_range(0, 3)), 4'($urandom_range(0, 1)), 3'($urandom)};
            rwe = 1'($urandom_range(0, 1));
            rwd = $urandom;
            do_req(rwe, ra, rwd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
